// File: rtl/spu_event_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spu_event_sink: captures SPU events into a FIFO with per-ID statistics.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spu_event_sink #(
  parameter int NUM_EVENT       = 5,
  parameter int EVENT_INFO_BITS = 8,
  parameter int NUM_SOURCE      = 2,
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_WIDTH       = 32,
  localparam int EVENT_ID_BITS  = $clog2(NUM_EVENT + 1),
  localparam int SOURCE_ID_BITS = $clog2(NUM_SOURCE),
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [EVENT_ID_BITS-1:0]   e_id_i,
  input  logic [EVENT_INFO_BITS-1:0] e_info_i,
  input  logic [SOURCE_ID_BITS-1:0]  s_id_i,
  output logic                       drain_valid_o,
  input  logic                       drain_ready_i,
  output logic [EVENT_ID_BITS-1:0]   drain_id_o,
  output logic [EVENT_INFO_BITS-1:0] drain_info_o,
  output logic [SOURCE_ID_BITS-1:0]  drain_sid_o,
  output logic [LVL_W-1:0]           fifo_level_o,
  input  logic [EVENT_ID_BITS-1:0]   cnt_sel_i,
  output logic [CNT_WIDTH-1:0]       cnt_o,
  output logic [CNT_WIDTH-1:0]       drop_cnt_o,
  input  logic                       cnt_clr_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if (NUM_SOURCE < 2) begin : g_chk_num_source
    $error("spu_event_sink: NUM_SOURCE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_fifo_depth
    $error("spu_event_sink: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (NUM_EVENT < 1) begin : g_chk_num_event
    $error("spu_event_sink: NUM_EVENT must be at least 1");
  end

  logic [EVENT_ID_BITS-1:0]   id_mem_q   [FIFO_DEPTH];
  logic [EVENT_INFO_BITS-1:0] info_mem_q [FIFO_DEPTH];
  logic [SOURCE_ID_BITS-1:0]  sid_mem_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]           level_q,  level_d;
  logic [CNT_WIDTH-1:0]       drop_q,   drop_d;
  logic [CNT_WIDTH-1:0]       cnt_q     [NUM_EVENT];

  logic w_ev_valid;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_ev_valid = enable_i && (e_id_i != '0) &&
                      (e_id_i <= EVENT_ID_BITS'(NUM_EVENT));
  assign w_full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign w_empty    = (level_q == '0);
  assign w_pop      = !w_empty && drain_ready_i;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign w_push     = w_ev_valid && (!w_full || w_pop);
  assign w_drop     = w_ev_valid && !w_push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (cnt_clr_i) begin
      drop_d = '0;
    end else if (w_drop && !(&drop_q)) begin
      drop_d = drop_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head fields are masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      id_mem_q[wr_ptr_q]   <= e_id_i;
      info_mem_q[wr_ptr_q] <= e_info_i;
      sid_mem_q[wr_ptr_q]  <= s_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  // Clear beats a coincident event, so that event is never counted.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      for (int k = 0; k < NUM_EVENT; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_EVENT; k++) begin
        if (w_ev_valid && (e_id_i == EVENT_ID_BITS'(k + 1)) && !(&cnt_q[k])) begin
          cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < NUM_EVENT; k++) begin
      if (cnt_sel_i == EVENT_ID_BITS'(k + 1)) begin
        cnt_o = cnt_q[k];
      end
    end
  end

  assign drain_valid_o = !w_empty;
  assign drain_id_o    = w_empty ? '0 : id_mem_q[rd_ptr_q];
  assign drain_info_o  = w_empty ? '0 : info_mem_q[rd_ptr_q];
  assign drain_sid_o   = w_empty ? '0 : sid_mem_q[rd_ptr_q];
  assign fifo_level_o  = level_q;
  assign drop_cnt_o    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_spu_event_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spu_event_sink: directed vectors plus multi-cycle corner sequences.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spu_event_sink;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [2:0] e_id_i;
  logic [7:0] e_info_i;
  logic       s_id_i;
  logic       drain_valid_o;
  logic       drain_ready_i;
  logic [2:0] drain_id_o;
  logic [7:0] drain_info_o;
  logic       drain_sid_o;
  logic [3:0] fifo_level_o;
  logic [2:0] cnt_sel_i;
  logic [3:0] cnt_o;
  logic [3:0] drop_cnt_o;
  logic       cnt_clr_i;

  int n_chk = 0;
  int n_err = 0;

  // Narrow counters so saturation is reachable in a short run.
  spu_event_sink #(
    .NUM_EVENT(5), .EVENT_INFO_BITS(8), .NUM_SOURCE(2),
    .FIFO_DEPTH(8), .CNT_WIDTH(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .e_id_i(e_id_i), .e_info_i(e_info_i), .s_id_i(s_id_i),
    .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i),
    .drain_id_o(drain_id_o), .drain_info_o(drain_info_o), .drain_sid_o(drain_sid_o),
    .fifo_level_o(fifo_level_o), .cnt_sel_i(cnt_sel_i), .cnt_o(cnt_o),
    .drop_cnt_o(drop_cnt_o), .cnt_clr_i(cnt_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst, en;
    logic [2:0] id;
    logic [7:0] info;
    logic       sid, rdy, clr;
    logic [2:0] sel;
    logic       ev;
    logic [2:0] eid;
    logic [7:0] einfo;
    logic       esid;
    logic [3:0] elvl, ecnt, edrop;
  } vec_t;

  vec_t vecs [10];

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rst, input logic en, input logic [2:0] id,
                       input logic [7:0] info, input logic sid, input logic rdy,
                       input logic clr, input logic [2:0] sel);
    rst_i = rst; enable_i = en; e_id_i = id; e_info_i = info; s_id_i = sid;
    drain_ready_i = rdy; cnt_clr_i = clr; cnt_sel_i = sel;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] snap();
    return {7'd0, drain_valid_o, drain_id_o, drain_info_o, drain_sid_o,
            fifo_level_o, cnt_o, drop_cnt_o};
  endfunction

  function automatic logic [31:0] head();
    return {19'd0, drain_valid_o, drain_id_o, drain_info_o, drain_sid_o};
  endfunction

  initial begin
    //          rst  en   id    info    sid  rdy  clr  sel    ev   eid   einfo   esid lvl   cnt   drop
    vecs[0] = '{1'b1,1'b0,3'd0,8'd0,  1'b0,1'b0,1'b0,3'd2, 1'b0,3'd0,8'd0,  1'b0,4'd0,4'd0,4'd0};
    vecs[1] = '{1'b0,1'b1,3'd2,8'd20, 1'b1,1'b1,1'b0,3'd2, 1'b1,3'd2,8'd20, 1'b1,4'd1,4'd1,4'd0};
    vecs[2] = '{1'b0,1'b1,3'd0,8'd0,  1'b0,1'b1,1'b0,3'd2, 1'b0,3'd0,8'd0,  1'b0,4'd0,4'd1,4'd0};
    vecs[3] = '{1'b0,1'b1,3'd0,8'd55, 1'b1,1'b1,1'b0,3'd0, 1'b0,3'd0,8'd0,  1'b0,4'd0,4'd0,4'd0};
    vecs[4] = '{1'b0,1'b1,3'd7,8'd66, 1'b1,1'b1,1'b0,3'd2, 1'b0,3'd0,8'd0,  1'b0,4'd0,4'd1,4'd0};
    vecs[5] = '{1'b0,1'b1,3'd6,8'd66, 1'b0,1'b1,1'b0,3'd2, 1'b0,3'd0,8'd0,  1'b0,4'd0,4'd1,4'd0};
    vecs[6] = '{1'b0,1'b0,3'd4,8'd77, 1'b1,1'b1,1'b0,3'd4, 1'b0,3'd0,8'd0,  1'b0,4'd0,4'd0,4'd0};
    vecs[7] = '{1'b0,1'b1,3'd0,8'd0,  1'b0,1'b1,1'b0,3'd7, 1'b0,3'd0,8'd0,  1'b0,4'd0,4'd0,4'd0};
    vecs[8] = '{1'b0,1'b1,3'd4,8'd77, 1'b1,1'b0,1'b0,3'd4, 1'b1,3'd4,8'd77, 1'b1,4'd1,4'd1,4'd0};
    vecs[9] = '{1'b0,1'b1,3'd0,8'd0,  1'b0,1'b1,1'b0,3'd4, 1'b0,3'd0,8'd0,  1'b0,4'd0,4'd1,4'd0};

    drive(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    cyc();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].id, vecs[i].info, vecs[i].sid,
            vecs[i].rdy, vecs[i].clr, vecs[i].sel);
      cyc();
      chk($sformatf("vec%0d", i), snap(),
          {7'd0, vecs[i].ev, vecs[i].eid, vecs[i].einfo, vecs[i].esid,
           vecs[i].elvl, vecs[i].ecnt, vecs[i].edrop});
    end

    // Overfill: 10 id=1 events into an 8-deep FIFO with no consumer.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 3'd1, 8'(i), 1'(i % 2), 1'b0, 1'b0, 3'd1);
      cyc();
    end
    chk("fill_level", fifo_level_o, 4'd8);
    chk("fill_drop", drop_cnt_o, 4'd2);
    chk("fill_cnt1", cnt_o, 4'd10);
    chk("fill_head", head(), {1'b1, 3'd1, 8'd0, 1'b0});

    // Push into a full FIFO while the head leaves.
    drive(1'b0, 1'b1, 3'd3, 8'd99, 1'b1, 1'b1, 1'b0, 3'd3);
    cyc();
    chk("fullpp_level", fifo_level_o, 4'd8);
    chk("fullpp_drop", drop_cnt_o, 4'd2);
    chk("fullpp_cnt3", cnt_o, 4'd1);

    drive(1'b0, 1'b1, 3'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd1);
    for (int k = 0; k < 8; k++) begin
      if (k < 7) chk($sformatf("drain%0d", k), head(), {1'b1, 3'd1, 8'(k + 1), 1'((k + 1) % 2)});
      else       chk($sformatf("drain%0d", k), head(), {1'b1, 3'd3, 8'd99, 1'b1});
      cyc();
    end
    chk("drain_empty", head(), 32'd0);
    chk("drain_level", fifo_level_o, 4'd0);

    // Clear coinciding with an event: event pushed but not counted.
    drive(1'b0, 1'b1, 3'd5, 8'd5, 1'b0, 1'b0, 1'b0, 3'd5);
    cyc();
    chk("pre_clr_cnt5", cnt_o, 4'd1);
    drive(1'b0, 1'b1, 3'd5, 8'd6, 1'b1, 1'b0, 1'b1, 3'd5);
    cyc();
    chk("clr_cnt5", cnt_o, 4'd0);
    chk("clr_drop", drop_cnt_o, 4'd0);
    chk("clr_level", fifo_level_o, 4'd2);
    drive(1'b0, 1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd1);
    chk("clr_cnt1", cnt_o, 4'd0);
    chk("clr_head0", head(), {1'b1, 3'd5, 8'd5, 1'b0});
    drive(1'b0, 1'b1, 3'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd1);
    cyc();
    chk("clr_head1", head(), {1'b1, 3'd5, 8'd6, 1'b1});
    cyc();
    chk("clr_drained", fifo_level_o, 4'd0);

    // Saturation of a per-ID counter and of the drop counter.
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 1'b1, 3'd2, 8'(i), 1'b0, 1'b0, 1'b0, 3'd2);
      cyc();
    end
    chk("sat_cnt2", cnt_o, 4'd15);
    chk("sat_drop", drop_cnt_o, 4'd15);
    chk("sat_level", fifo_level_o, 4'd8);
    drive(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd2);
    cyc();

    // Mid-operation reset with an event presented in the reset cycle.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 3'd3, 8'(i), 1'b0, 1'b0, 1'b0, 3'd3);
      cyc();
    end
    chk("rst_pre_level", fifo_level_o, 4'd3);
    drive(1'b1, 1'b1, 3'd3, 8'd9, 1'b1, 1'b1, 1'b1, 3'd3);
    cyc();
    drive(1'b0, 1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    chk("rst_snap", snap(), 32'd0);
    drive(1'b0, 1'b1, 3'd4, 8'd44, 1'b1, 1'b0, 1'b0, 3'd4);
    cyc();
    chk("rst_after", snap(), {7'd0, 1'b1, 3'd4, 8'd44, 1'b1, 4'd1, 4'd1, 4'd0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
